// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared states, blank code and constant helpers for the BCD converter
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } bcd_state_e;

    // Digit code the seg7 decoder renders dark
    localparam logic [3:0] BCD_BLANK = 4'hF;

    function automatic int pow10(input int n);
        int r;
        r = 1;
        for (int i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// rtl/bcd_digit_adj.sv - double-dabble add-3 correction for one BCD digit
module bcd_digit_adj (
    input  logic [3:0] din,
    output logic [3:0] dout
);

    assign dout = (din > 4'd4) ? din + 4'd3 : din;

endmodule

// File: rtl/bcd_convert_ctrl.sv
// rtl/bcd_convert_ctrl.sv - sequential binary-to-BCD converter; BCD_CONV_BLANK_EN enables leading-zero blanking
module bcd_convert_ctrl
    import bcd_pkg::*;
#(
    parameter int BIN_W  = 14,
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [BIN_W-1:0]      in_bin,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   out_bcd,
    output logic                  overflow
);

    localparam int          BCD_W = 4 * DIGITS;
    localparam int          CNT_W = clog2(BIN_W + 1);
    localparam logic [31:0] MAX   = 32'(pow10(DIGITS) - 1);

    localparam logic [1:0] S_IDLE  = IDLE;
    localparam logic [1:0] S_SHIFT = SHIFT;
    localparam logic [1:0] S_DONE  = DONE;

    logic [1:0]       state;
    logic [BIN_W-1:0] bin_r;
    logic [BCD_W-1:0] bcd_r;
    logic [CNT_W-1:0] cnt;
    logic             ovf_r;

    logic [31:0]      in_wide;
    logic [BCD_W-1:0] bcd_adj;
    logic [BCD_W-1:0] bcd_next;
    logic [BCD_W-1:0] bcd_done;

    assign in_wide = 32'(in_bin);

    genvar g;
    generate
        for (g = 0; g < DIGITS; g++) begin : g_adj
            bcd_digit_adj u_adj (
                .din  (bcd_r[4*g +: 4]),
                .dout (bcd_adj[4*g +: 4])
            );
        end
    endgenerate

    // The accumulator MSB never carries out since the loaded value is bounded by MAX
    assign bcd_next = (bcd_adj << 1) | BCD_W'(bin_r[BIN_W-1]);

`ifdef BCD_CONV_BLANK_EN
    function automatic logic [BCD_W-1:0] blank_lz(input logic [BCD_W-1:0] v);
        logic lead;
        blank_lz = v;
        lead     = 1'b1;
        for (int d = DIGITS - 1; d >= 1; d--) begin
            if (lead && (v[4*d +: 4] == 4'd0)) blank_lz[4*d +: 4] = BCD_BLANK;
            else                               lead = 1'b0;
        end
    endfunction

    // A saturated result stays as raw nines so it reads as overflow
    assign bcd_done = ovf_r ? bcd_next : blank_lz(bcd_next);
`else
    assign bcd_done = bcd_next;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            bin_r <= '0;
            bcd_r <= '0;
            cnt   <= '0;
            ovf_r <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        if (in_wide > MAX) begin
                            bin_r <= MAX[BIN_W-1:0];
                            ovf_r <= 1'b1;
                        end else begin
                            bin_r <= in_bin;
                            ovf_r <= 1'b0;
                        end
                        bcd_r <= '0;
                        cnt   <= CNT_W'(BIN_W);
                        state <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    bin_r <= bin_r << 1;
                    cnt   <= cnt - 1'b1;
                    if (cnt == CNT_W'(1)) begin
                        bcd_r <= bcd_done;
                        state <= S_DONE;
                    end else begin
                        bcd_r <= bcd_next;
                    end
                end
                S_DONE: begin
                    if (out_ready) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state == S_DONE);
    assign out_bcd   = bcd_r;
    assign overflow  = ovf_r;

endmodule

// File: tb/tb_bcd_convert_ctrl.sv
// tb/tb_bcd_convert_ctrl.sv - scoreboard bench for bcd_convert_ctrl at 4 and 2 digits
module tb_bcd_convert_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        iv0 = 1'b0, or0 = 1'b0;
    logic [13:0] ib0 = '0;
    logic        ir0, ov0, of0;
    logic [15:0] ob0;

    logic        iv1 = 1'b0, or1 = 1'b0;
    logic [6:0]  ib1 = '0;
    logic        ir1, ov1, of1;
    logic [7:0]  ob1;

    bcd_convert_ctrl u0 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv0), .in_ready(ir0), .in_bin(ib0),
        .out_valid(ov0), .out_ready(or0), .out_bcd(ob0), .overflow(of0)
    );

    bcd_convert_ctrl #(.BIN_W(7), .DIGITS(2)) u1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .in_bin(ib1),
        .out_valid(ov1), .out_ready(or1), .out_bcd(ob1), .overflow(of1)
    );

    logic        sel = 1'b0;
    logic        cur_ir, cur_ov, cur_of;
    logic [23:0] cur_ob;
    assign cur_ir = sel ? ir1 : ir0;
    assign cur_ov = sel ? ov1 : ov0;
    assign cur_of = sel ? of1 : of0;
    assign cur_ob = sel ? 24'(ob1) : 24'(ob0);

    int          n_cmp = 0;
    int          n_err = 0;
    logic [24:0] sbq[$];
    logic [24:0] last_exp;
    int          lat;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: decimal division, saturation, optional blanking
    function automatic logic [24:0] model(input int v, input int digits);
        int          maxv, x;
        logic        ovf;
        logic [23:0] r;
        maxv = 1;
        for (int i = 0; i < digits; i++) maxv = maxv * 10;
        maxv = maxv - 1;
        ovf  = (v > maxv);
        x    = ovf ? maxv : v;
        r    = '0;
        for (int d = 0; d < digits; d++) begin
            r[4*d +: 4] = 4'(x % 10);
            x = x / 10;
        end
`ifdef BCD_CONV_BLANK_EN
        if (!ovf) begin
            for (int d = digits - 1; d >= 1; d--) begin
                if (r[4*d +: 4] != 4'd0) break;
                r[4*d +: 4] = 4'hF;
            end
        end
`endif
        return {ovf, r};
    endfunction

    task automatic set_in(input int v, input logic valid);
        if (sel) begin iv1 = valid; ib1 = 7'(v); end
        else     begin iv0 = valid; ib0 = 14'(v); end
    endtask

    task automatic set_or(input logic r);
        if (sel) or1 = r;
        else     or0 = r;
    endtask

    task automatic start(input int v);
        @(negedge clk);
        chk("in_ready_idle", 32'(cur_ir), 32'd1);
        set_in(v, 1'b1);
        @(posedge clk);
        sbq.push_back(model(v, sel ? 2 : 4));
        #1;
        set_in(0, 1'b0);
        chk("in_ready_drop", 32'(cur_ir), 32'd0);
    endtask

    task automatic wait_out(input int exp_lat);
        lat = 1;
        while (!cur_ov && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
            if (!cur_ov) chk("in_ready_busy", 32'(cur_ir), 32'd0);
        end
        chk("latency", lat, exp_lat);
        chk("sb_nonempty", 32'(sbq.size() != 0), 32'd1);
        if (sbq.size() != 0) begin
            last_exp = sbq.pop_front();
            chk("out_bcd", 32'(cur_ob), 32'(last_exp[23:0]));
            chk("overflow", 32'(cur_of), 32'(last_exp[24]));
        end
    endtask

    task automatic release_out();
        @(negedge clk);
        set_or(1'b1);
        @(posedge clk);
        #1;
        set_or(1'b0);
        chk("out_valid_clear", 32'(cur_ov), 32'd0);
        chk("in_ready_back", 32'(cur_ir), 32'd1);
    endtask

    initial begin
        // Reset state
        #12;
        chk("rst_in_ready", 32'(ir0), 32'd1);
        chk("rst_out_valid", 32'(ov0), 32'd0);
        chk("rst_out_bcd", 32'(ob0), 32'd0);
        chk("rst_overflow", 32'(of0), 32'd0);
        chk("rst_out_valid_d2", 32'(ov1), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // 1: basic conversion
        start(255);
        wait_out(15);
        release_out();

        // 2: all nines then zero back-to-back; early out_ready has no effect
        set_or(1'b1);
        start(9999);
        wait_out(15);
        release_out();
        set_or(1'b1);
        start(0);
        wait_out(15);
        release_out();

        // 3: overflow saturates at same latency
        start(12345);
        wait_out(15);
        release_out();

        // 4: output held under backpressure, input ignored while busy
        start(1234);
        wait_out(15);
        @(negedge clk);
        set_in(7, 1'b1);
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            chk("hold_valid", 32'(cur_ov), 32'd1);
            chk("hold_bcd", 32'(cur_ob), 32'(last_exp[23:0]));
            chk("hold_in_ready", 32'(cur_ir), 32'd0);
        end
        set_in(0, 1'b0);
        release_out();
        start(7);
        wait_out(15);
        release_out();

        // 5: asynchronous reset mid-shift discards the pending result
        start(4321);
        repeat (6) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_in_ready", 32'(ir0), 32'd1);
        chk("arst_out_valid", 32'(ov0), 32'd0);
        chk("arst_out_bcd", 32'(ob0), 32'd0);
        chk("arst_overflow", 32'(of0), 32'd0);
        if (sbq.size() != 0) void'(sbq.pop_front());
        @(negedge clk);
        rst_n = 1'b1;
        start(42);
        wait_out(15);
        release_out();

        // 6: two-digit, 7-bit instance
        sel = 1'b1;
        start(99);
        wait_out(8);
        release_out();
        start(100);
        wait_out(8);
        release_out();
        start(5);
        wait_out(8);
        release_out();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/bcd_convert_ctrl.md
Name: bcd_convert_ctrl

Overview:
Sequential Binary-to-BCD conversion controller for the sale-terminal 7-segment display path. It accepts wide binary values (price, total, change) over a valid/ready handshake. It runs a one-bit-per-cycle double-dabble shift/add-3 sequence and presents packed BCD digits to the display decoder over a second valid/ready handshake. It replaces per-digit combinational converters and supports multi-digit values.

Parameters:
BIN_W, 14, width of binary input; supported range 4..20.
DIGITS, 4, number of BCD output digits; supported range 1..6.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
in_valid  in  1  in_bin is valid.
in_ready  out  1  block can accept a value.
in_bin  in  BIN_W  unsigned binary value.
out_valid  out  1  out_bcd and overflow are valid.
out_ready  in  1  consumer accepts the result.
out_bcd  out  4*DIGITS  packed BCD; digit 0 in [3:0], most significant digit at the top.
overflow  out  1  in_bin exceeded MAX; result saturated.

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: state=IDLE, in_ready=1, out_valid=0, out_bcd=0, overflow=0, bit counter=0.
- Constant: MAX = 10^DIGITS-1 (9999 at default).
- FSM states and transitions:
  - IDLE: in_ready=1. On in_valid&in_ready:
    - If in_bin>MAX, load the shift register with MAX and set ovf_r=1; otherwise load in_bin and set ovf_r=0.
    - Clear the BCD accumulator, set cnt=BIN_W, go to SHIFT.
  - SHIFT: in_ready=0. Each cycle:
    - For every digit, if digit>4, add 3 (4-bit wrap never occurs).
    - Shift {bcd,bin} left by one; the MSB of bin enters bcd[0].
    - Decrement cnt. When cnt reaches 1 in this cycle, go to DONE.
  - DONE: out_valid=1. out_bcd and overflow are driven from registers and held stable until out_valid&out_ready, then return to IDLE.
- Latency: exactly BIN_W+1 cycles from the accepting edge to out_valid=1 (15 at default).
- Throughput: one conversion per BIN_W+2 cycles minimum. in_ready is high only in IDLE; the earliest next accept is the cycle after the output handshake.
- Boundary conditions:
  - in_valid while busy: ignored, no state change.
  - out_ready high before DONE: no effect.
  - out_ready held low: out_valid and out_bcd are held indefinitely.
  - Output handshake: out_bcd is not modified while out_valid=1.
  - in_bin=0: result 0, normal latency.
  - in_bin=MAX: result is all 9s with overflow=0.
  - Overflow path: uses the same latency as the normal path.
  - rst_n asserted mid-SHIFT or in DONE: immediate return to reset values; the pending result is discarded.
- out_bcd width: out_bcd is the low 4*DIGITS bits of the accumulator. The accumulator is exactly 4*DIGITS bits, which suffices because the loaded value is never greater than MAX.

Optional Feature:
BCD_CONV_BLANK_EN
- Defined: leading-zero blanking is applied when entering DONE.
  - Every digit above the most significant non-zero digit is replaced with BCD_BLANK (4'hF), which the seg7 decoder renders dark.
  - Digit 0 is never blanked.
  - The overflow result is never blanked.
- Not defined: raw BCD with leading zeros is output. No extra logic is present.

Decomposition:
- Package bcd_pkg holds:
  - state enum {IDLE, SHIFT, DONE};
  - BCD_BLANK=4'hF;
  - a constant function pow10(DIGITS) used to derive MAX;
  - a constant function clog2 for the counter width.
- Sub-module bcd_digit_adj: a 4-bit combinational unit that adds 3 when the digit is greater than 4. It is instantiated DIGITS times via generate.
- The FSM, counter and registers stay in bcd_convert_ctrl.

Test Plan:
1. Reset release, then in_bin=255 with in_valid pulse -> in_ready drops the next cycle; out_valid rises 15 cycles after acceptance; out_bcd=16'h0255, overflow=0 (with BLANK_EN: 16'hF255).
2. in_bin=9999, then in_bin=0 back-to-back -> 16'h9999, overflow=0; then 16'h0000 (with BLANK_EN: 16'hFFF0); in_ready low throughout each conversion.
3. in_bin=12345 -> out_bcd=16'h9999, overflow=1, latency 15, not blanked.
4. out_ready held low 20 cycles after out_valid -> out_valid and out_bcd stable; in_valid=1 with in_bin=7 during the hold is ignored; release out_ready -> IDLE, then 7 is accepted and yields 16'h0007.
5. rst_n pulsed low at SHIFT cycle 6 of in_bin=4321 -> all outputs at reset values asynchronously; after release, in_bin=42 converts to 16'h0042 with no residue.
6. DIGITS=2, BIN_W=7: in_bin=99 -> 8'h99; in_bin=100 -> 8'h99 with overflow=1; latency 8.
